serial_add_ctrl: RTL



---
 rtl/serial_add_pkg.sv | 12 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state encoding and default operand width for the serial adder
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer, one bit per clock through a single fa_cell.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic             s, c, last;

    fa_cell u_fa (
        .x  (a_r[0]),
        .y  (b_r[0]),
        .ci (carry),
        .s  (s),
        .co (c)
    );

    assign last = cnt == CW'(WIDTH - 1);
    assign sum  = (state == SHIFT) ? '0 : sum_r;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next state and state-decoded handshake outputs
    always_comb begin
        state_n = (state == IDLE)  ? (start ? SHIFT : IDLE) :
                  (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
        ready   = state == IDLE;
        busy    = state == SHIFT;
        done    = state == DONE;
    end

    // operand load, LSB-first shift, carry chaining and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            cnt   <= '0;
            carry <= cin;
            a_r   <= a;
            b_r   <= b;
            sum_r <= '0;
        end else if (state == SHIFT) begin
            cnt   <= cnt + CW'(1);
            carry <= c;
            a_r   <= a_r >> 1;
            b_r   <= b_r >> 1;
            sum_r <= (sum_r >> 1) | (WIDTH'(s) << (WIDTH - 1));
            if (last) begin
                cout <= c;
`ifdef SERIAL_ADD_OVF_EN
                ovf  <= carry ^ c;
`endif
            end
        end
    end

endmodule
